// File: rtl/tcp_stream_pkg.sv
// Shared definitions for the two-source TCP payload stream arbiter.
//  DEFAULT_DATA_W : default stream data width
//  state_t        : arbiter FSM states (idle / owned by src0 / owned by src1)
//  GNT_*          : one-hot grant encodings
package tcp_stream_pkg;

  localparam int unsigned DEFAULT_DATA_W = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_S0   = 2'b01;
  localparam logic [1:0] GNT_S1   = 2'b10;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-request round-robin picker.
//  req        : request bits, bit0 = src0, bit1 = src1
//  last_owner : source that completed the previous packet (0 = src0, 1 = src1)
//  pick       : one-hot winner, 00 when nothing is requested
module rr_pick2
  import tcp_stream_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] pick
);

  always_comb begin
    pick = GNT_NONE;
    case (req)
      2'b01:   pick = GNT_S0;
      2'b10:   pick = GNT_S1;
      // Contention goes to whichever source did not finish last.
      2'b11:   pick = last_owner ? GNT_S0 : GNT_S1;
      default: pick = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/tcp_stream_arb2.sv
// Packet-granular round-robin arbiter merging two AXI-Stream sources onto one
// datapath. A grant is held from the first beat through the tlast beat, with
// one arbitration (idle) cycle before each packet.
//  clk, nrst            : clock, asynchronous active-low reset
//  s0_* / s1_*          : ingress streams (tvalid, tlast, tdata in; tready out)
//  m_*                  : merged stream (tvalid, tlast, tdata out; tready in)
//  m_beat               : 0-based beat index of current m_tdata, saturating
//  grant                : one-hot owner (01 src0, 10 src1, 00 none)
//  pkt_cnt0 / pkt_cnt1  : saturating counts of completed packets per source
module tcp_stream_arb2
  import tcp_stream_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned BEAT_W  = 21,
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               s0_tvalid,
  input  logic               s0_tlast,
  input  logic [DATA_W-1:0]  s0_tdata,
  output logic               s0_tready,
  input  logic               s1_tvalid,
  input  logic               s1_tlast,
  input  logic [DATA_W-1:0]  s1_tdata,
  output logic               s1_tready,
  output logic               m_tvalid,
  output logic               m_tlast,
  output logic [DATA_W-1:0]  m_tdata,
  input  logic               m_tready,
  output logic [BEAT_W-1:0]  m_beat,
  output logic [1:0]         grant,
  output logic [COUNT_W-1:0] pkt_cnt0,
  output logic [COUNT_W-1:0] pkt_cnt1
);

  state_t     state;
  logic       last_owner;
  logic [1:0] pick;
  logic       xfer;

  rr_pick2 u_pick (
    .req        ({s1_tvalid, s0_tvalid}),
    .last_owner (last_owner),
    .pick       (pick)
  );

  // Zero-latency mux from the owning source; nothing is offered while idle.
  always_comb begin
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    m_tdata   = '0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    case (state)
      ST_OWN0: begin
        m_tvalid  = s0_tvalid;
        m_tlast   = s0_tlast;
        m_tdata   = s0_tdata;
        s0_tready = m_tready;
      end
      ST_OWN1: begin
        m_tvalid  = s1_tvalid;
        m_tlast   = s1_tlast;
        m_tdata   = s1_tdata;
        s1_tready = m_tready;
      end
      default: ;
    endcase
  end

  assign xfer = m_tvalid & m_tready;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= ST_IDLE;
      grant      <= GNT_NONE;
      last_owner <= 1'b1;
      m_beat     <= '0;
      pkt_cnt0   <= '0;
      pkt_cnt1   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          m_beat <= '0;
          if (pick[0]) begin
            state <= ST_OWN0;
            grant <= GNT_S0;
          end else if (pick[1]) begin
            state <= ST_OWN1;
            grant <= GNT_S1;
          end
        end
        ST_OWN0, ST_OWN1: begin
          if (xfer) begin
            if (m_tlast) begin
              state      <= ST_IDLE;
              grant      <= GNT_NONE;
              m_beat     <= '0;
              last_owner <= (state == ST_OWN1);
              if (state == ST_OWN0) begin
                if (pkt_cnt0 != '1) pkt_cnt0 <= pkt_cnt0 + COUNT_W'(1);
              end else begin
                if (pkt_cnt1 != '1) pkt_cnt1 <= pkt_cnt1 + COUNT_W'(1);
              end
            end else if (m_beat != '1) begin
              m_beat <= m_beat + BEAT_W'(1);
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          grant  <= GNT_NONE;
          m_beat <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_stream_arb2.sv
module tb_tcp_stream_arb2;

  localparam int DW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          nrst;
  logic          s0_tvalid, s0_tlast, s0_tready;
  logic          s1_tvalid, s1_tlast, s1_tready;
  logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
  logic          m_tvalid, m_tlast, m_tready;
  logic [20:0]   m_beat;
  logic [1:0]    grant;
  logic [31:0]   pkt_cnt0, pkt_cnt1;

  logic          sat_s0_tready, sat_s1_tready, sat_tvalid, sat_tlast;
  logic [DW-1:0] sat_tdata;
  logic [1:0]    sat_beat, sat_grant;
  logic [2:0]    sat_cnt0, sat_cnt1;

  int checks;
  int passed;

  tcp_stream_arb2 u_dut (
    .clk(clk), .nrst(nrst),
    .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tdata(s0_tdata), .s0_tready(s0_tready),
    .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tdata(s1_tdata), .s1_tready(s1_tready),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tdata(m_tdata), .m_tready(m_tready),
    .m_beat(m_beat), .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  tcp_stream_arb2 #(.BEAT_W(2), .COUNT_W(3)) u_sat (
    .clk(clk), .nrst(nrst),
    .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tdata(s0_tdata), .s0_tready(sat_s0_tready),
    .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tdata(s1_tdata), .s1_tready(sat_s1_tready),
    .m_tvalid(sat_tvalid), .m_tlast(sat_tlast), .m_tdata(sat_tdata), .m_tready(m_tready),
    .m_beat(sat_beat), .grant(sat_grant), .pkt_cnt0(sat_cnt0), .pkt_cnt1(sat_cnt1)
  );

  function automatic logic [DW-1:0] tag(input int s, input int p, input int b);
    logic [DW-1:0] t;
    t = '0;
    t[31:24] = 8'(s);
    t[23:8]  = 16'(p);
    t[7:0]   = 8'(b);
    return t;
  endfunction

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_tdata = '0;
    s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tdata = '0;
    m_tready  = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    nrst = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    s0_tvalid = 1'b1; s1_tvalid = 1'b1;
    nrst = 1'b0;
    #2;
    checks++; if (grant !== 2'b00) $display("FAIL rst_grant got=%b want=00", grant); else passed++;
    checks++; if (m_tvalid !== 1'b0) $display("FAIL rst_tvalid got=%b want=0", m_tvalid); else passed++;
    checks++; if (m_beat !== 21'd0) $display("FAIL rst_beat got=%0d want=0", m_beat); else passed++;
    checks++; if (pkt_cnt0 !== 32'd0) $display("FAIL rst_cnt0 got=%0d want=0", pkt_cnt0); else passed++;
    checks++; if (pkt_cnt1 !== 32'd0) $display("FAIL rst_cnt1 got=%0d want=0", pkt_cnt1); else passed++;
    checks++; if ({s1_tready, s0_tready} !== 2'b00) $display("FAIL rst_tready got=%b want=00", {s1_tready, s0_tready}); else passed++;
    tick();
    checks++; if (grant !== 2'b00) $display("FAIL rst_hold_grant got=%b want=00", grant); else passed++;
    idle_inputs();
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_three_beat();
    logic [DW-1:0] d [3];
    do_reset();
    for (int i = 0; i < 3; i++) d[i] = rnd256();
    s0_tvalid = 1'b1; s0_tlast = 1'b0; s0_tdata = d[0];
    #1;
    checks++; if (m_tvalid !== 1'b0) $display("FAIL t1_bubble got=%b want=0", m_tvalid); else passed++;
    tick();
    for (int i = 0; i < 3; i++) begin
      s0_tdata = d[i]; s0_tlast = (i == 2);
      #1;
      checks++; if (grant !== 2'b01) $display("FAIL t1_grant beat=%0d got=%b want=01", i, grant); else passed++;
      checks++; if (m_tvalid !== 1'b1) $display("FAIL t1_tvalid beat=%0d got=%b want=1", i, m_tvalid); else passed++;
      checks++; if (m_tdata !== d[i]) $display("FAIL t1_tdata beat=%0d got=%h want=%h", i, m_tdata, d[i]); else passed++;
      checks++; if (m_beat !== 21'(i)) $display("FAIL t1_beat got=%0d want=%0d", m_beat, i); else passed++;
      checks++; if (m_tlast !== (i == 2)) $display("FAIL t1_tlast beat=%0d got=%b", i, m_tlast); else passed++;
      checks++; if ({s1_tready, s0_tready} !== 2'b01) $display("FAIL t1_tready got=%b want=01", {s1_tready, s0_tready}); else passed++;
      tick();
    end
    s0_tvalid = 1'b0; s0_tlast = 1'b0;
    #1;
    checks++; if (grant !== 2'b00) $display("FAIL t1_end_grant got=%b want=00", grant); else passed++;
    checks++; if (pkt_cnt0 !== 32'd1) $display("FAIL t1_cnt0 got=%0d want=1", pkt_cnt0); else passed++;
    checks++; if (pkt_cnt1 !== 32'd0) $display("FAIL t1_cnt1 got=%0d want=0", pkt_cnt1); else passed++;
  endtask

  task automatic test_alternate();
    int idx [2];
    int pk [2];
    int own, bt;
    do_reset();
    idx = '{0, 0}; pk = '{0, 0};
    for (int k = 0; k < 12; k++) begin
      s0_tvalid = 1'b1; s0_tlast = (idx[0] == 1); s0_tdata = tag(0, pk[0], idx[0]);
      s1_tvalid = 1'b1; s1_tlast = (idx[1] == 1); s1_tdata = tag(1, pk[1], idx[1]);
      #1;
      if (k % 3 == 0) begin
        checks++; if ({grant, m_tvalid} !== 3'b000) $display("FAIL t2_idle k=%0d got=%b want=000", k, {grant, m_tvalid}); else passed++;
      end else begin
        own = (k / 3) % 2;
        bt  = (k % 3) - 1;
        checks++; if (grant !== ((own == 0) ? 2'b01 : 2'b10)) $display("FAIL t2_grant k=%0d got=%b own=%0d", k, grant, own); else passed++;
        checks++; if (m_tdata !== tag(own, (k / 3) / 2, bt)) $display("FAIL t2_tdata k=%0d got=%h want=%h", k, m_tdata, tag(own, (k / 3) / 2, bt)); else passed++;
        checks++; if (m_beat !== 21'(bt)) $display("FAIL t2_beat k=%0d got=%0d want=%0d", k, m_beat, bt); else passed++;
        if (idx[own] == 1) begin idx[own] = 0; pk[own]++; end else idx[own]++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    s1_tvalid = 1'b1; s1_tlast = 1'b0; s1_tdata = tag(1, 0, 0);
    #1;
    checks++; if (grant !== 2'b00) $display("FAIL t3_bubble got=%b want=00", grant); else passed++;
    tick();
    checks++; if (grant !== 2'b10) $display("FAIL t3_grant got=%b want=10", grant); else passed++;
    checks++; if (m_beat !== 21'd0) $display("FAIL t3_beat0 got=%0d want=0", m_beat); else passed++;
    tick();
    s1_tdata = tag(1, 0, 1); m_tready = 1'b0;
    s0_tvalid = 1'b1; s0_tlast = 1'b1; s0_tdata = tag(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (m_tdata !== tag(1, 0, 1)) $display("FAIL t3_hold_data i=%0d got=%h", i, m_tdata); else passed++;
      checks++; if (m_beat !== 21'd1) $display("FAIL t3_hold_beat i=%0d got=%0d want=1", i, m_beat); else passed++;
      checks++; if ({s1_tready, s0_tready} !== 2'b00) $display("FAIL t3_hold_tready i=%0d got=%b want=00", i, {s1_tready, s0_tready}); else passed++;
      checks++; if (grant !== 2'b10) $display("FAIL t3_hold_grant i=%0d got=%b want=10", i, grant); else passed++;
      tick();
    end
    m_tready = 1'b1;
    #1;
    checks++; if ({s1_tready, s0_tready} !== 2'b10) $display("FAIL t3_go_tready got=%b want=10", {s1_tready, s0_tready}); else passed++;
    checks++; if (m_beat !== 21'd1) $display("FAIL t3_go_beat got=%0d want=1", m_beat); else passed++;
    tick();
    s1_tdata = tag(1, 0, 2); s1_tlast = 1'b1;
    #1;
    checks++; if (m_beat !== 21'd2) $display("FAIL t3_last_beat got=%0d want=2", m_beat); else passed++;
    checks++; if (s0_tready !== 1'b0) $display("FAIL t3_last_s0rdy got=%b want=0", s0_tready); else passed++;
    tick();
    s1_tvalid = 1'b0; s1_tlast = 1'b0;
    #1;
    checks++; if (grant !== 2'b00) $display("FAIL t3_idle_grant got=%b want=00", grant); else passed++;
    checks++; if (pkt_cnt1 !== 32'd1) $display("FAIL t3_cnt1 got=%0d want=1", pkt_cnt1); else passed++;
    tick();
    checks++; if (grant !== 2'b01) $display("FAIL t3_next_grant got=%b want=01", grant); else passed++;
    checks++; if (m_tdata !== tag(0, 0, 0)) $display("FAIL t3_next_data got=%h", m_tdata); else passed++;
    tick();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int pk;
    do_reset();
    pk = 0;
    s0_tvalid = 1'b1; s0_tlast = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s0_tdata = tag(0, pk, 0);
      #1;
      checks++; if (m_tvalid !== (k % 2 == 1)) $display("FAIL t4_tvalid k=%0d got=%b", k, m_tvalid); else passed++;
      if (k % 2 == 1) begin
        checks++; if (m_tdata !== tag(0, k / 2, 0)) $display("FAIL t4_tdata k=%0d got=%h", k, m_tdata); else passed++;
        checks++; if (m_beat !== 21'd0) $display("FAIL t4_beat k=%0d got=%0d want=0", k, m_beat); else passed++;
        pk++;
      end else begin
        checks++; if (s0_tready !== 1'b0) $display("FAIL t4_idle_rdy k=%0d got=%b want=0", k, s0_tready); else passed++;
      end
      tick();
    end
    s0_tvalid = 1'b0;
    #1;
    checks++; if (pkt_cnt0 !== 32'd5) $display("FAIL t4_cnt0 got=%0d want=5", pkt_cnt0); else passed++;
  endtask

  task automatic test_count_sat();
    do_reset();
    s1_tvalid = 1'b1; s1_tlast = 1'b1;
    for (int n = 0; n < 9; n++) begin
      s1_tdata = tag(1, n, 0);
      #1;
      tick();
      checks++; if (m_tdata !== tag(1, n, 0)) $display("FAIL t5_tdata n=%0d got=%h", n, m_tdata); else passed++;
      tick();
      checks++; if (pkt_cnt1 !== 32'(n + 1)) $display("FAIL t5_cnt1 n=%0d got=%0d want=%0d", n, pkt_cnt1, n + 1); else passed++;
      checks++; if (sat_cnt1 !== 3'(imin(n + 1, 7))) $display("FAIL t5_sat_cnt1 n=%0d got=%0d want=%0d", n, sat_cnt1, imin(n + 1, 7)); else passed++;
    end
    checks++; if (sat_cnt0 !== 3'd0) $display("FAIL t5_sat_cnt0 got=%0d want=0", sat_cnt0); else passed++;
    idle_inputs();
  endtask

  task automatic test_beat_sat();
    do_reset();
    s0_tvalid = 1'b1; s0_tlast = 1'b0; s0_tdata = tag(0, 0, 0);
    #1;
    tick();
    for (int i = 0; i < 6; i++) begin
      s0_tdata = tag(0, 0, i); s0_tlast = (i == 5);
      #1;
      checks++; if (m_beat !== 21'(i)) $display("FAIL tb_beat i=%0d got=%0d want=%0d", i, m_beat, i); else passed++;
      checks++; if (sat_beat !== 2'(imin(i, 3))) $display("FAIL tb_sat_beat i=%0d got=%0d want=%0d", i, sat_beat, imin(i, 3)); else passed++;
      tick();
    end
    s0_tvalid = 1'b0; s0_tlast = 1'b0;
    #1;
    checks++; if (sat_beat !== 2'd0) $display("FAIL tb_sat_beat_end got=%0d want=0", sat_beat); else passed++;
    checks++; if (sat_cnt0 !== 3'd1) $display("FAIL tb_sat_cnt0 got=%0d want=1", sat_cnt0); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    s0_tvalid = 1'b1; s0_tlast = 1'b0; s0_tdata = tag(0, 0, 0);
    #1;
    tick();
    for (int i = 0; i < 2; i++) begin
      s0_tdata = tag(0, 0, i);
      #1;
      tick();
    end
    s0_tdata = tag(0, 0, 2);
    #1;
    checks++; if (m_beat !== 21'd2) $display("FAIL t6_pre_beat got=%0d want=2", m_beat); else passed++;
    nrst = 1'b0;
    #1;
    checks++; if (grant !== 2'b00) $display("FAIL t6_grant got=%b want=00", grant); else passed++;
    checks++; if (m_tvalid !== 1'b0) $display("FAIL t6_tvalid got=%b want=0", m_tvalid); else passed++;
    checks++; if (m_beat !== 21'd0) $display("FAIL t6_beat got=%0d want=0", m_beat); else passed++;
    checks++; if (pkt_cnt0 !== 32'd0) $display("FAIL t6_cnt0 got=%0d want=0", pkt_cnt0); else passed++;
    tick();
    nrst = 1'b1;
    s0_tvalid = 1'b1; s0_tlast = 1'b1; s0_tdata = tag(0, 9, 0);
    s1_tvalid = 1'b1; s1_tlast = 1'b1; s1_tdata = tag(1, 9, 0);
    #1;
    checks++; if (grant !== 2'b00) $display("FAIL t6_rel_idle got=%b want=00", grant); else passed++;
    tick();
    checks++; if (grant !== 2'b01) $display("FAIL t6_rel_grant got=%b want=01", grant); else passed++;
    checks++; if (m_tdata !== tag(0, 9, 0)) $display("FAIL t6_rel_data got=%h", m_tdata); else passed++;
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    int own, last, beat;
    int cnt [2];
    int act [2];
    int len [2];
    int idx [2];
    logic v [2];
    logic l [2];
    logic acc [2];
    logic [DW-1:0] d [2];
    logic e_tv, e_tl;
    logic [DW-1:0] e_d;
    logic [1:0] e_g, e_rdy;
    do_reset();
    own = -1; last = 1; beat = 0;
    cnt = '{0, 0}; act = '{0, 0}; len = '{1, 1}; idx = '{0, 0};
    v = '{1'b0, 1'b0}; l = '{1'b0, 1'b0}; d = '{'0, '0};
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!v[i]) begin
          if (act[i] == 0 && $urandom_range(0, 3) == 0) begin
            act[i] = 1; len[i] = $urandom_range(1, 5); idx[i] = 0;
          end
          if (act[i] != 0 && $urandom_range(0, 3) != 0) begin
            v[i] = 1'b1; d[i] = rnd256(); l[i] = (idx[i] == len[i] - 1);
          end
        end
      end
      s0_tvalid = v[0]; s0_tlast = l[0]; s0_tdata = d[0];
      s1_tvalid = v[1]; s1_tlast = l[1]; s1_tdata = d[1];
      m_tready = ($urandom_range(0, 3) != 0);
      if (own < 0) begin
        e_tv = 1'b0; e_tl = 1'b0; e_d = '0; e_g = 2'b00; e_rdy = 2'b00;
      end else begin
        e_tv = v[own]; e_tl = l[own]; e_d = d[own];
        e_g = (own == 0) ? 2'b01 : 2'b10;
        e_rdy = (own == 0) ? {1'b0, m_tready} : {m_tready, 1'b0};
      end
      #1;
      checks++; if (grant !== e_g) $display("FAIL rnd_grant k=%0d got=%b want=%b", k, grant, e_g); else passed++;
      checks++; if (m_tvalid !== e_tv) $display("FAIL rnd_tvalid k=%0d got=%b want=%b", k, m_tvalid, e_tv); else passed++;
      checks++; if ({s1_tready, s0_tready} !== e_rdy) $display("FAIL rnd_tready k=%0d got=%b want=%b", k, {s1_tready, s0_tready}, e_rdy); else passed++;
      checks++; if (m_beat !== 21'(beat)) $display("FAIL rnd_beat k=%0d got=%0d want=%0d", k, m_beat, beat); else passed++;
      checks++; if (sat_beat !== 2'(imin(beat, 3))) $display("FAIL rnd_sat_beat k=%0d got=%0d want=%0d", k, sat_beat, imin(beat, 3)); else passed++;
      checks++; if (pkt_cnt0 !== 32'(cnt[0]) || pkt_cnt1 !== 32'(cnt[1])) $display("FAIL rnd_cnt k=%0d got=%0d,%0d want=%0d,%0d", k, pkt_cnt0, pkt_cnt1, cnt[0], cnt[1]); else passed++;
      checks++; if (sat_cnt0 !== 3'(imin(cnt[0], 7)) || sat_cnt1 !== 3'(imin(cnt[1], 7))) $display("FAIL rnd_sat_cnt k=%0d got=%0d,%0d", k, sat_cnt0, sat_cnt1); else passed++;
      checks++; if ({sat_grant, sat_tvalid, sat_s1_tready, sat_s0_tready} !== {e_g, e_tv, e_rdy}) $display("FAIL rnd_sat_ctl k=%0d got=%b want=%b", k, {sat_grant, sat_tvalid, sat_s1_tready, sat_s0_tready}, {e_g, e_tv, e_rdy}); else passed++;
      if (e_tv) begin
        checks++; if (m_tdata !== e_d || m_tlast !== e_tl) $display("FAIL rnd_data k=%0d got=%h/%b want=%h/%b", k, m_tdata, m_tlast, e_d, e_tl); else passed++;
        checks++; if (sat_tdata !== e_d || sat_tlast !== e_tl) $display("FAIL rnd_sat_data k=%0d got=%h/%b", k, sat_tdata, sat_tlast); else passed++;
      end
      for (int i = 0; i < 2; i++) acc[i] = v[i] && e_rdy[i];
      if (own < 0) begin
        if (v[0] && v[1]) own = (last == 0) ? 1 : 0;
        else if (v[0]) own = 0;
        else if (v[1]) own = 1;
        beat = 0;
      end else if (acc[own]) begin
        if (l[own]) begin
          cnt[own]++; last = own; own = -1; beat = 0;
        end else begin
          beat++;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          v[i] = 1'b0;
          if (l[i]) act[i] = 0; else idx[i]++;
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    passed = 0;
    idle_inputs();
    test_reset();
    test_three_beat();
    test_alternate();
    test_backpressure();
    test_back_to_back();
    test_count_sat();
    test_beat_sat();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
